// File: rtl/dcache_writeback_buffer.sv
// Word-granular write buffer between the dcache controller and memory: coalesces
// stores into unlocked entries, drains in order via req/ack/done, and serves load lookups.
module dcache_writeback_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PLEN  = 34,
    parameter int unsigned XLEN  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [PLEN-1:0]   wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [XLEN/8-1:0] wb_be_i,
    input  logic              flush_i,
    output logic              empty_o,
    input  logic [PLEN-1:0]   lookup_addr_i,
    output logic              lookup_hit_o,
    output logic [XLEN-1:0]   lookup_data_o,
    output logic [XLEN/8-1:0] lookup_be_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    input  logic              mem_done_i,
    output logic [PLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_data_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [2:0]        mem_size_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned WADDR_W = PLEN - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_e;

    logic [DEPTH-1:0]   valid_q;
    logic [WADDR_W-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]    data_q [DEPTH];
    logic [BE_W-1:0]    be_q   [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    state_e             state_q;
    logic               mem_req_q;

    logic               match_hit;
    logic [PTR_W-1:0]   match_idx;
    logic               push_fire, push_new, pop;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^{wb_addr_i[1:0], lookup_addr_i[1:0]};

    function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] head, input int k);
        return head + PTR_W'(k);
    endfunction

    // Coalesce target: the head is excluded while the drain FSM owns it
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[age_idx(head_q, k)]
                && addr_q[age_idx(head_q, k)] == wb_addr_i[PLEN-1:2]
                && !(age_idx(head_q, k) == head_q && state_q != IDLE)) begin
                match_hit = 1'b1;
                match_idx = age_idx(head_q, k);
            end
        end
    end

    // Walk oldest to youngest so the youngest match wins
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        lookup_be_o   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[age_idx(head_q, k)]
                && addr_q[age_idx(head_q, k)] == lookup_addr_i[PLEN-1:2]) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = data_q[age_idx(head_q, k)];
                lookup_be_o   = be_q[age_idx(head_q, k)];
            end
        end
    end

    assign wb_ready_o = !flush_i && (count_q < CNT_W'(DEPTH) || match_hit);
    assign push_fire  = wb_valid_i && wb_ready_o;
    assign push_new   = push_fire && !match_hit;
    assign pop        = (state_q == REQ && mem_ack_i && mem_done_i)
                     || (state_q == WAIT_DONE && mem_done_i);

    assign empty_o    = (count_q == '0) && (state_q == IDLE);
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = {addr_q[head_q], 2'b00};
    assign mem_data_o = data_q[head_q];
    assign mem_be_o   = be_q[head_q];
    assign mem_size_o = 3'b010;

    // Payload storage, not reset
    always_ff @(posedge clk_i) begin
        if (push_new) begin
            addr_q[tail_q] <= wb_addr_i[PLEN-1:2];
            data_q[tail_q] <= wb_data_i;
            be_q[tail_q]   <= wb_be_i;
        end else if (push_fire) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wb_be_i[b]) begin
                    data_q[match_idx][8*b +: 8] <= wb_data_i[8*b +: 8];
                end
            end
            be_q[match_idx] <= be_q[match_idx] | wb_be_i;
        end
    end

    // Pointers, occupancy and drain FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            if (push_new) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({push_new, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_done_i ? IDLE : WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mem_done_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed self-checking bench for dcache_writeback_buffer.
module tb_dcache_writeback_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [33:0] wb_addr_i;
    logic [31:0] wb_data_i;
    logic [3:0]  wb_be_i;
    logic        flush_i;
    logic        empty_o;
    logic [33:0] lookup_addr_i;
    logic        lookup_hit_o;
    logic [31:0] lookup_data_o;
    logic [3:0]  lookup_be_o;
    logic        mem_req_o;
    logic        mem_ack_i;
    logic        mem_done_i;
    logic [33:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic [2:0]  mem_size_o;

    int n_tests = 0;
    int n_fail  = 0;

    dcache_writeback_buffer #(.DEPTH(4), .PLEN(34), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .wb_be_i(wb_be_i), .flush_i(flush_i), .empty_o(empty_o),
        .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
        .lookup_data_o(lookup_data_o), .lookup_be_o(lookup_be_o),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_done_i(mem_done_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
        .mem_size_o(mem_size_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be);
        wb_valid_i = 1'b1;
        wb_addr_i  = a;
        wb_data_i  = d;
        wb_be_i    = be;
        @(posedge clk_i);
        #1 wb_valid_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int cyc = 0;
        @(negedge clk_i);
        while (!mem_req_o && cyc < 8) begin
            @(negedge clk_i);
            cyc++;
        end
        check({tag, "_req"}, 64'(mem_req_o), 64'd1);
    endtask

    // Waits for a request, checks the head payload, then acks and completes in one cycle
    task automatic drain(input string tag, input logic [33:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        wait_req(tag);
        check({tag, "_addr"}, 64'(mem_addr_o), 64'(a));
        check({tag, "_data"}, 64'(mem_data_o), 64'(d));
        check({tag, "_be"},   64'(mem_be_o),   64'(be));
        mem_ack_i  = 1'b1;
        mem_done_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b0;
        mem_done_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; wb_be_i = '0;
        flush_i = 1'b0; lookup_addr_i = '0; mem_ack_i = 1'b0; mem_done_i = 1'b0;

        // Reset state
        #23;
        check("rst_req",   64'(mem_req_o),    64'd0);
        check("rst_empty", 64'(empty_o),      64'd1);
        check("rst_ready", 64'(wb_ready_o),   64'd1);
        check("rst_hit",   64'(lookup_hit_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single push, ack, done three cycles later
        push(34'h1000, 32'hDEADBEEF, 4'hF);
        wait_req("t1");
        check("t1_addr", 64'(mem_addr_o), 64'h1000);
        check("t1_data", 64'(mem_data_o), 64'hDEADBEEF);
        check("t1_be",   64'(mem_be_o),   64'hF);
        check("t1_size", 64'(mem_size_o), 64'h2);
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("t1_req_drop", 64'(mem_req_o), 64'd0);
        check("t1_busy",     64'(empty_o),   64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 mem_done_i = 1'b1;
        @(posedge clk_i);
        #1 mem_done_i = 1'b0;
        @(negedge clk_i);
        check("t1_empty", 64'(empty_o), 64'd1);

        // Coalesce two byte writes before the drain locks the entry
        @(posedge clk_i);
        #1;
        push(34'h2000, 32'h000000AA, 4'h1);
        push(34'h2002, 32'h00BB0000, 4'h4);
        drain("t2", 34'h2000, 32'h00BB00AA, 4'h5);
        @(negedge clk_i);
        check("t2_empty", 64'(empty_o), 64'd1);

        // Fill to capacity while the head is held; only an unlocked match is accepted
        push(34'h4000, 32'h40404040, 4'hF);
        push(34'h4010, 32'h10101010, 4'hF);
        push(34'h4020, 32'h20202020, 4'hF);
        push(34'h4030, 32'h30303030, 4'hF);
        @(negedge clk_i);
        wb_addr_i = 34'h4040;
        #1 check("t3_full_refuse", 64'(wb_ready_o), 64'd0);
        wb_addr_i = 34'h4000;
        #1 check("t3_locked_refuse", 64'(wb_ready_o), 64'd0);
        wb_addr_i = 34'h4020;
        #1 check("t3_match_accept", 64'(wb_ready_o), 64'd1);
        push(34'h4020, 32'h00000055, 4'h1);
        lookup_addr_i = 34'h4020;
        @(negedge clk_i);
        check("t3_lk_hit",  64'(lookup_hit_o),  64'd1);
        check("t3_lk_data", 64'(lookup_data_o), 64'h20202055);
        check("t3_lk_be",   64'(lookup_be_o),   64'hF);
        drain("t3a", 34'h4000, 32'h40404040, 4'hF);
        drain("t3b", 34'h4010, 32'h10101010, 4'hF);
        drain("t3c", 34'h4020, 32'h20202055, 4'hF);
        drain("t3d", 34'h4030, 32'h30303030, 4'hF);
        @(negedge clk_i);
        check("t3_empty", 64'(empty_o), 64'd1);

        // Push to the locked head's address creates a new, younger entry
        push(34'h3000, 32'hAAAAAAAA, 4'hF);
        wait_req("t4_lock");
        push(34'h3000, 32'h11111111, 4'hF);
        lookup_addr_i = 34'h3000;
        @(negedge clk_i);
        check("t4_lk_hit",  64'(lookup_hit_o),  64'd1);
        check("t4_lk_data", 64'(lookup_data_o), 64'h11111111);
        drain("t4a", 34'h3000, 32'hAAAAAAAA, 4'hF);
        drain("t4b", 34'h3000, 32'h11111111, 4'hF);
        @(negedge clk_i);
        check("t4_empty", 64'(empty_o), 64'd1);

        // Flush blocks pushes, including coalescing ones, while draining continues
        push(34'h5000, 32'h00005000, 4'hF);
        push(34'h5004, 32'h00005004, 4'hF);
        @(negedge clk_i);
        flush_i   = 1'b1;
        wb_addr_i = 34'h5004;
        #1 check("t5_ready", 64'(wb_ready_o), 64'd0);
        drain("t5a", 34'h5000, 32'h00005000, 4'hF);
        drain("t5b", 34'h5004, 32'h00005004, 4'hF);
        @(negedge clk_i);
        check("t5_empty", 64'(empty_o), 64'd1);
        flush_i = 1'b0;

        // Reset while waiting for done with three entries queued
        push(34'h6000, 32'h6000, 4'hF);
        push(34'h6004, 32'h6004, 4'hF);
        push(34'h6008, 32'h6008, 4'hF);
        wait_req("t6");
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
        lookup_addr_i = 34'h6004;
        @(negedge clk_i);
        check("t6_wait_req", 64'(mem_req_o),    64'd0);
        check("t6_wait_hit", 64'(lookup_hit_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_req",   64'(mem_req_o),    64'd0);
        check("t6_rst_empty", 64'(empty_o),      64'd1);
        check("t6_rst_hit",   64'(lookup_hit_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check("t6_post_req",   64'(mem_req_o), 64'd0);
        check("t6_post_empty", 64'(empty_o),   64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1);
    end

endmodule
